// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and helpers for the FIFO word packer
//
// Purpose : byte/lane sizing constants, lane-count and keep types, and the
//           count-to-keep mask helper used when a word leaves the accumulator.
// Ports   : none (package).
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int PACK_LANES      = 4;

    // Holds 0..PACK_LANES inclusive, so one bit wider than a lane index.
    typedef logic [2:0] lane_cnt_t;
    typedef logic [PACK_LANES-1:0] keep_t;

    // Contiguous mask of the low cnt lanes: (1 << cnt) - 1.
    function automatic keep_t keep_from_count(input lane_cnt_t cnt);
        logic [PACK_LANES:0] one_hot;
        one_hot = (PACK_LANES+1)'(1) << cnt;
        return keep_t'(one_hot - (PACK_LANES+1)'(1));
    endfunction

endpackage

// File: rtl/pack_out_reg.sv
// rtl/pack_out_reg.sv - single-entry valid/ready output holding register
//
// Purpose : holds one packed word and its keep mask until the consumer accepts it.
// Ports   : clk, rst (async active-low)
//           load, load_data, load_keep  - new word from the accumulator
//           m_data, m_keep, m_valid, m_ready - output stream
//           free - register can take a word this cycle (empty or draining now)
module pack_out_reg
    import fifo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  keep_t            load_keep,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output keep_t            m_keep,
    output logic             m_valid,
    output logic             free
);

    logic [WIDTH-1:0] data_q, data_d;
    keep_t            keep_q, keep_d;
    logic             valid_q, valid_d;

    always_comb begin
        free    = !valid_q || m_ready;
        data_d  = data_q;
        keep_d  = keep_q;
        valid_d = valid_q;
        if (load) begin
            data_d  = load_data;
            keep_d  = load_keep;
            valid_d = 1'b1;
        end else if (valid_q && m_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            keep_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            keep_q  <= keep_d;
            valid_q <= valid_d;
        end
    end

    assign m_data  = data_q;
    assign m_keep  = keep_q;
    assign m_valid = valid_q;

endmodule

// File: rtl/fifo_word_packer.sv
// rtl/fifo_word_packer.sv - drains a byte FIFO and packs four bytes per output word
//
// Purpose : reads bytes through re/r_data/empty, accumulates them lane 0 upward,
//           and emits full words, or partial words on flush or idle timeout.
// Ports   : clk, rst (async active-low)
//           fifo_re, fifo_r_data, fifo_empty - FIFO read side (1-cycle data latency)
//           flush - one-cycle request to emit the partial word
//           m_data, m_keep, m_valid, m_ready - packed output stream
//           busy  - bytes held, read in flight, or flush outstanding
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int LANES      = PACK_LANES,
    parameter int TIMEOUT    = 16,
    parameter int TO_W       = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        fifo_re,
    input  logic [DATA_WIDTH-1:0]       fifo_r_data,
    input  logic                        fifo_empty,
    input  logic                        flush,
    output logic [DATA_WIDTH*LANES-1:0] m_data,
    output logic [LANES-1:0]            m_keep,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        busy
);

    localparam int WORD_W = DATA_WIDTH * LANES;
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);
    localparam lane_cnt_t FULL_CNT = lane_cnt_t'(LANES);

    lane_cnt_t                        count_q, count_d;
    logic                             inflight_q, inflight_d;
    logic [LANES-1:0][DATA_WIDTH-1:0] acc_q, acc_d;
    logic [TO_W-1:0]                  to_cnt_q, to_cnt_d;
    logic                             flush_pending_q, flush_pending_d;

    logic              out_free;
    logic              timeout_hit;
    logic              part_move;
    logic              move;
    logic [1:0]        cap_idx;
    keep_t             move_keep;
    logic [WORD_W-1:0] move_data;

    always_comb begin
        timeout_hit = (TIMEOUT != 0) && (to_cnt_q == TO_LIMIT);
        // A partial word may only leave once no byte is still on its way in.
        part_move   = (flush_pending_q || timeout_hit) && (count_q != '0) && !inflight_q;
        move        = out_free && ((count_q == FULL_CNT) || part_move);

        // Gated by rst so nothing is popped while the packer is held in reset.
        fifo_re = rst && !fifo_empty && !flush_pending_q
                  && ((count_q + lane_cnt_t'(inflight_q)) < FULL_CNT);

        move_keep = keep_from_count(count_q);
        for (int i = 0; i < LANES; i++) begin
            move_data[i*DATA_WIDTH +: DATA_WIDTH] = move_keep[i] ? acc_q[i] : '0;
        end

        // A byte landing in the same cycle as a move starts the fresh word.
        cap_idx = move ? 2'd0 : count_q[1:0];
        acc_d   = acc_q;
        count_d = move ? '0 : count_q;
        if (inflight_q) begin
            acc_d[cap_idx] = fifo_r_data;
            count_d        = count_d + lane_cnt_t'(1);
        end
        inflight_d = fifo_re;

        to_cnt_d = to_cnt_q;
        if (move || inflight_q || (count_q == '0)) begin
            to_cnt_d = '0;
        end else if ((TIMEOUT != 0) && fifo_empty && (to_cnt_q != TO_LIMIT)) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end

        // Held until the accumulator has fully drained; new flushes meanwhile are absorbed.
        if (flush_pending_q) begin
            flush_pending_d = !((count_q == '0) && !inflight_q);
        end else begin
            flush_pending_d = flush;
        end

        busy = (count_q != '0) || inflight_q || flush_pending_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q         <= '0;
            inflight_q      <= 1'b0;
            acc_q           <= '0;
            to_cnt_q        <= '0;
            flush_pending_q <= 1'b0;
        end else begin
            count_q         <= count_d;
            inflight_q      <= inflight_d;
            acc_q           <= acc_d;
            to_cnt_q        <= to_cnt_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    pack_out_reg #(
        .WIDTH (WORD_W)
    ) u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (move),
        .load_data (move_data),
        .load_keep (move_keep),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_keep    (m_keep),
        .m_valid   (m_valid),
        .free      (out_free)
    );

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb/tb_fifo_word_packer.sv - directed self-checking bench for fifo_word_packer
module tb_fifo_word_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_re;
    logic [7:0]  fifo_r_data = 8'h00;
    logic        fifo_empty;
    logic        flush;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_valid;
    logic        m_ready;
    logic        busy;

    logic        nt_re;
    logic [7:0]  nt_rdata = 8'h00;
    logic        nt_empty;
    logic        nt_flush = 1'b0;
    logic [31:0] nt_data;
    logic [3:0]  nt_keep;
    logic        nt_valid;
    logic        nt_ready = 1'b1;
    logic        nt_busy;
    logic        nt_valid_seen = 1'b0;

    logic [7:0]  mem [0:255];
    int          wp = 0;
    int          rp = 0;
    int          nt_wp = 0;
    int          nt_rp = 0;
    int          rd_cnt = 0;
    int          underruns = 0;
    logic [35:0] rx_q [$];
    int          rx_base = 0;
    int          n_assert = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    assign fifo_empty = (wp == rp);
    assign nt_empty   = (nt_wp == nt_rp);

    fifo_word_packer #(.TIMEOUT(16), .TO_W(5)) dut (
        .clk (clk), .rst (rst),
        .fifo_re (fifo_re), .fifo_r_data (fifo_r_data), .fifo_empty (fifo_empty),
        .flush (flush),
        .m_data (m_data), .m_keep (m_keep), .m_valid (m_valid), .m_ready (m_ready),
        .busy (busy)
    );

    fifo_word_packer #(.TIMEOUT(0), .TO_W(5)) dut_nt (
        .clk (clk), .rst (rst),
        .fifo_re (nt_re), .fifo_r_data (nt_rdata), .fifo_empty (nt_empty),
        .flush (nt_flush),
        .m_data (nt_data), .m_keep (nt_keep), .m_valid (nt_valid), .m_ready (nt_ready),
        .busy (nt_busy)
    );

    // FIFO model and output capture
    always @(posedge clk) begin
        if (fifo_re === 1'b1) begin
            if (wp == rp) begin
                underruns++;
            end else begin
                fifo_r_data <= mem[rp];
                rp <= rp + 1;
                rd_cnt++;
            end
        end
        if (m_valid === 1'b1 && m_ready === 1'b1) rx_q.push_back({m_keep, m_data});
        if (nt_re === 1'b1 && nt_wp != nt_rp) begin
            nt_rdata <= 8'h5A;
            nt_rp <= nt_rp + 1;
        end
        if (nt_valid === 1'b1) nt_valid_seen = 1'b1;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wp] = b;
        wp++;
    endtask

    task automatic wait_words(input int n, input int budget);
        int k = 0;
        while (rx_q.size() < rx_base + n && k < budget) begin
            tick();
            k++;
        end
        chk("wait_words", 36'(rx_q.size() >= rx_base + n), 36'd1);
    endtask

    initial begin
        logic re_any;
        logic v_any;
        int   rd_base;
        int   un_base;

        rst = 1'b1;
        flush = 1'b0;
        m_ready = 1'b1;
        #2 rst = 1'b0;
        tick();
        tick();
        chk("rst_fifo_re", 36'(fifo_re), 36'd0);
        chk("rst_m_valid", 36'(m_valid), 36'd0);
        chk("rst_m_data", 36'(m_data), 36'd0);
        chk("rst_m_keep", 36'(m_keep), 36'd0);
        chk("rst_busy", 36'(busy), 36'd0);
        rst = 1'b1;
        tick();

        // Full word with m_ready held high
        rx_base = rx_q.size();
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_re_high_%0d", i), 36'(fifo_re), 36'd1);
            tick();
        end
        chk("t1_re_low", 36'(fifo_re), 36'd0);
        wait_words(1, 20);
        chk("t1_word", rx_q[rx_base], {4'hF, 32'h44332211});
        chk("t1_empty", 36'(fifo_empty), 36'd1);
        chk("t1_underrun", 36'(underruns), 36'd0);
        tick();
        chk("t1_busy", 36'(busy), 36'd0);

        // Backpressure: eight bytes buffered, then drained in order
        rx_base = rx_q.size();
        rd_base = rd_cnt;
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'(i));
        for (int i = 0; i < 12; i++) tick();
        chk("t2_reads", 36'(rd_cnt - rd_base), 36'd8);
        chk("t2_re_stall", 36'(fifo_re), 36'd0);
        chk("t2_valid_held", 36'(m_valid), 36'd1);
        chk("t2_data_held", {m_keep, m_data}, {4'hF, 32'h04030201});
        chk("t2_busy", 36'(busy), 36'd1);
        m_ready = 1'b1;
        wait_words(2, 20);
        chk("t2_word0", rx_q[rx_base], {4'hF, 32'h04030201});
        chk("t2_word1", rx_q[rx_base+1], {4'hF, 32'h08070605});
        chk("t2_underrun", 36'(underruns), 36'd0);
        chk("t2_empty", 36'(fifo_empty), 36'd1);

        // Flush of a two-byte partial word
        tick();
        rx_base = rx_q.size();
        push(8'hAA); push(8'hBB);
        for (int i = 0; i < 4; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t3_busy_pending", 36'(busy), 36'd1);
        wait_words(1, 20);
        chk("t3_word", rx_q[rx_base], {4'h3, 32'h0000BBAA});
        chk("t3_busy_after_accept", 36'(busy), 36'd0);

        // Idle timeout on a single byte; the TIMEOUT=0 instance gets the same byte
        tick();
        rx_base = rx_q.size();
        push(8'h5A);
        nt_wp++;
        for (int i = 0; i < 18; i++) tick();
        chk("t4_not_yet", 36'(m_valid), 36'd0);
        tick();
        chk("t4_valid", 36'(m_valid), 36'd1);
        chk("t4_word", {m_keep, m_data}, {4'h1, 32'h0000005A});
        wait_words(1, 5);
        for (int i = 0; i < 25; i++) tick();
        chk("t4_nt_never_valid", 36'(nt_valid_seen), 36'd0);
        chk("t4_nt_busy", 36'(nt_busy), 36'd1);

        // Asynchronous reset with three bytes captured and one in flight
        push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
        for (int i = 0; i < 4; i++) tick();
        chk("t5_busy_before", 36'(busy), 36'd1);
        rst = 1'b0;
        #1;
        chk("t5_fifo_re", 36'(fifo_re), 36'd0);
        chk("t5_m_valid", 36'(m_valid), 36'd0);
        chk("t5_m_data", 36'(m_data), 36'd0);
        chk("t5_m_keep", 36'(m_keep), 36'd0);
        chk("t5_busy", 36'(busy), 36'd0);
        rx_base = rx_q.size();
        push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
        #1;
        chk("t5_re_in_reset", 36'(fifo_re), 36'd0);
        tick();
        tick();
        rst = 1'b1;
        wait_words(1, 20);
        chk("t5_clean_word", rx_q[rx_base], {4'hF, 32'hD4D3D2D1});

        // Empty FIFO with flush pulses and toggling ready
        tick();
        rx_base = rx_q.size();
        un_base = underruns;
        re_any = 1'b0;
        v_any = 1'b0;
        for (int i = 0; i < 20; i++) begin
            flush = (i % 5 == 0);
            m_ready = i[0];
            tick();
            re_any = re_any | fifo_re;
            v_any = v_any | m_valid;
        end
        flush = 1'b0;
        tick();
        chk("t6_re_never", 36'(re_any), 36'd0);
        chk("t6_valid_never", 36'(v_any), 36'd0);
        chk("t6_no_words", 36'(rx_q.size() - rx_base), 36'd0);
        chk("t6_underrun", 36'(underruns - un_base), 36'd0);
        chk("t6_busy", 36'(busy), 36'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
- Downstream consumer of the 8-bit synchronous FIFO.
- Drains bytes using the FIFO's re/r_data/empty interface and packs four bytes into one 32-bit word.
- Presents each word on a valid/ready output stream, with byte-keep for partial words.
- A partial word is emitted on an explicit flush, or after a programmable idle timeout.

Parameters:
- DATA_WIDTH, 8: FIFO byte width. The packer is fixed at 4 lanes.
- LANES, 4: bytes per output word. Output width is DATA_WIDTH*LANES.
- TIMEOUT, 16: idle cycles with a partial word before auto-emit. 0 disables the timeout.
- TO_W, 5: timeout counter width. Must satisfy TO_W >= clog2(TIMEOUT+1).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- fifo_re  out  1  read strobe to the FIFO
- fifo_r_data  in  8  FIFO read data, valid the cycle after fifo_re is sampled high
- fifo_empty  in  1  FIFO empty flag
- flush  in  1  single-cycle request to emit the partial word
- m_data  out  32  packed word; first byte read is in [7:0]
- m_keep  out  4  byte-lane valid mask; lanes are contiguous from lane 0
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accept
- busy  out  1  high when the accumulator holds bytes or a read is in flight

Behaviour:
- Reset (rst=0, asynchronous) clears the following, regardless of state or in-flight read:
  - fifo_re=0, m_valid=0, m_data=0, m_keep=0, busy=0.
  - Accumulator count=0, inflight=0, timeout counter=0, flush_pending=0.
- FIFO read latency is one cycle:
  - The byte requested by fifo_re=1 at edge n is captured at edge n+1 into lane[count].
  - count then increments.
- fifo_re is combinational. It is 1 only when all of these hold:
  - fifo_empty=0, flush_pending=0;
  - count + inflight < 4, where inflight is 0 or 1.
- Reads can occur on consecutive cycles, giving a throughput of 1 byte/clock.
- fifo_re is never asserted while fifo_empty=1, so the packer never causes a FIFO underrun.
- Output register: holds one word.
  - A word transfers when m_valid && m_ready.
  - m_data and m_keep are stable while m_valid=1 and m_ready=0.
- Accumulator → output move:
  - Happens when count==4, or when a partial-emit condition holds with count>0 and inflight==0.
  - Also requires the output register to be free (m_valid=0, or m_valid && m_ready in the same cycle).
  - On the move: m_keep = (1<<count)-1, unused lanes of m_data = 0, count←0.
- A byte captured in the same cycle as a move goes to lane 0 of the cleared accumulator.
- Backpressure:
  - While the output is full and unaccepted, the accumulator keeps filling up to 4 bytes.
  - fifo_re then stalls until the move occurs.
  - Max buffering is 8 bytes (output + accumulator).
- Flush:
  - flush=1 sets flush_pending.
  - flush_pending holds fifo_re low. Bytes already in flight are still captured.
  - The partial word (or full word) is then emitted.
  - flush_pending clears once count==0 and inflight==0.
  - A flush with an empty accumulator emits nothing and clears the next cycle.
  - flush asserted while flush_pending is already set is ignored.
- Timeout (TIMEOUT>0):
  - The counter increments each cycle with count>0, inflight==0, fifo_empty=1.
  - It clears on any byte capture and on any move.
  - Reaching TIMEOUT forces a partial emit, with the same rules as flush.
- busy = (count!=0) | inflight | flush_pending.
- Simultaneous events:
  - A full accumulator move takes priority; flush applies to the remainder.
  - A timeout and a flush in the same cycle produce a single emit.

Decomposition:
- Package fifo_pkg holds:
  - FIFO_DATA_WIDTH=8, PACK_LANES=4.
  - typedef lane_cnt_t (3 bits, holds 0..4).
  - typedef keep_t (4 bits).
  - function keep_from_count.
- One sub-module is natural: pack_out_reg, the single-entry valid/ready output holding register (data, keep, valid). The top handles read control, accumulator, flush and timeout.

Test Plan:
- Write 0x11,0x22,0x33,0x44 into the FIFO, m_ready=1:
  - fifo_re asserts for 4 consecutive cycles.
  - One word m_data=0x44332211, m_keep=4'b1111.
  - FIFO ends empty and no underrun occurs.
- Write 8 bytes 0x01..0x08, m_ready=0 for 12 cycles, then 1:
  - fifo_re deasserts after 8 reads.
  - Words 0x04030201 then 0x08070605 are accepted in order.
  - FIFO remains empty and is never underrun.
- Write 0xAA,0xBB, pulse flush after 4 cycles:
  - m_data=0x0000BBAA, m_keep=4'b0011.
  - busy drops the cycle after the accept.
- Write 0x5A only, TIMEOUT=16, no flush:
  - Partial word m_data=0x0000005A, m_keep=4'b0001 appears 16 cycles after the capture plus the move cycle.
  - With TIMEOUT=0, no word ever appears.
- Assert rst=0 mid-word, after 3 bytes captured and 1 in flight:
  - All outputs are 0 immediately (asynchronous).
  - After release, the next 4 FIFO bytes form a clean word starting at lane 0.
- Hold fifo_empty=1 with flush pulses and m_ready toggling:
  - fifo_re is never 1.
  - m_valid is never 1.
